display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for an N-digit 7-segment display in the display controller path. It sequences a per-digit slot counter and a digit-select counter, decodes one 4-bit hex nibble per slot, and drives active-low anodes and segments with a blanking interval between digits to suppress ghosting. New display values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new data.

## Interface
- DIGITS, 4: number of multiplexed digits; 2..8.
- PRESCALE, 50000: clock cycles per digit slot; ≥ 2.
- BLANK, 500: cycles at the start of each slot with all anodes off; 0 ≤ BLANK < PRESCALE.

- i_Clk  in  1  clock; all logic on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_En  in  1  scan enable; low forces IDLE with the display off.
- i_Load  in  1  one-cycle strobe that captures i_Data and i_Dp into the pending buffer.
- i_Data  in  4*DIGITS  hex nibbles; digit k = i_Data[4k+3:4k], digit 0 least significant.
- i_Dp  in  DIGITS  decimal point per digit, active-high.
- o_Seg  out  7  segments a..g = bits 0..6, active-low.
- o_Dp  out  1  decimal point, active-low.
- o_An  out  DIGITS  one-hot anode select, active-low; o_An[k] enables digit k.
- o_Frame  out  1  one-cycle pulse at the end of each full scan frame.

## Operation
- Registers: state {IDLE, BLANKING, SHOW}, slot counter `cnt` (0..PRESCALE-1), digit index `dig` (0..DIGITS-1), pending buffer, display buffer.
- Reset: state IDLE; cnt = 0; dig = 0; both buffers cleared. Outputs: o_Seg = 7'h7F, o_Dp = 1, o_An all ones, o_Frame = 0.
- IDLE: anodes off, segments off, cnt = 0, dig = 0.
  - The pending buffer is copied into the display buffer every cycle.
  - When i_En = 1, go to BLANKING (or to SHOW if BLANK = 0).
- Each cycle in BLANKING or SHOW, cnt increments.
  - BLANKING → SHOW when cnt reaches BLANK-1.
  - At cnt = PRESCALE-1: cnt → 0, dig advances, state → BLANKING (SHOW if BLANK = 0).
  - dig wraps from DIGITS-1 to 0.
- Display during SHOW:
  - o_An[dig] = 0 and all other anodes = 1.
  - o_Seg = hex decode of the display nibble `dig`.
  - o_Dp = ~dp[dig].
- Display during BLANKING: anodes all 1, segments all 1.
- Frame boundary: the cycle with cnt = PRESCALE-1 and dig = DIGITS-1.
  - o_Frame pulses on this cycle.
  - The pending buffer is copied into the display buffer on this cycle.
- i_Load: pending buffer ← {i_Data, i_Dp} on the next edge. A later load overwrites an earlier one; only the last load before a boundary is shown.
- Simultaneous i_Load and frame boundary: the newly presented i_Data/i_Dp go directly into the display buffer, bypassing pending.
- i_En deassert mid-slot: IDLE on the next edge, display off, dig and cnt return to 0. Re-enable restarts at digit 0 with a full blanking interval.
- i_Rst mid-frame: everything returns to its reset values on that edge, including the pending buffer.
- Hex decode (active-low, g..a):
  - 0 = 40h, 1 = 79h, 2 = 24h, 3 = 30h
  - 4 = 19h, 5 = 12h, 6 = 02h, 7 = 78h
  - 8 = 00h, 9 = 10h, A = 08h, b = 03h
  - C = 46h, d = 21h, E = 06h, F = 0Eh

## Timing
- All outputs are registered and change on the same edge as the state/cnt/dig update. There is no combinational path from inputs to outputs.
- Slot length: exactly PRESCALE cycles. Frame length: DIGITS × PRESCALE cycles.
- Per slot: BLANK cycles dark, then PRESCALE-BLANK cycles lit.
- Start-up: i_En rising at edge t gives the first lit cycle at edge t+1+BLANK.
- A load becomes visible at the first frame boundary after the capture edge. Worst-case latency is one frame plus one cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Any digit k > 0 whose nibble and all higher nibbles are 0 shows o_Seg = 7'h7F in its SHOW phase.
  - Its anode timing is unchanged, and its DP is still honoured.
  - Digit 0 is always shown.
  - Suppression is computed from the display buffer.
- Undefined: every digit is decoded, including leading zeros. No suppression logic is instantiated.

## Test plan
All scenarios use DIGITS = 4, PRESCALE = 8, BLANK = 2.
- Reset and enable:
  - Stimulus: hold i_Rst for 3 cycles with i_En = 1, then release.
  - Required: o_An = 4'hF and o_Seg = 7'h7F during reset. After release, 2 dark cycles, then o_An = 4'b1110 for 6 cycles.
- Scan order and frame pulse:
  - Stimulus: load i_Data = 16'h4321 while IDLE, then enable.
  - Required: the slots show 79h, 24h, 30h, 19h on o_An = 1110, 1101, 1011, 0111. o_Frame pulses once every 32 cycles, on the last cycle of digit 3.
- Tear-free update:
  - Stimulus: issue i_Load with 16'h8888 during digit 1 of a frame showing 16'h4321.
  - Required: digits 2–3 of that frame still show 30h/19h. The next frame shows 00h on all digits.
- Load coincident with boundary:
  - Stimulus: i_Load with 16'hFFFF on the o_Frame cycle.
  - Required: the next digit 0 shows 0Eh.
- Disable mid-slot:
  - Stimulus: drop i_En at cnt = 4 of digit 2, then re-enable after 5 cycles.
  - Required: o_An = 4'hF the next cycle. The restart lights digit 0 after 2 dark cycles.
- Decimal point and leading zeros:
  - Stimulus: i_Data = 16'h0050, i_Dp = 4'b0010.
  - Required: o_Dp = 0 only in digit 1's SHOW phase.
  - With LEADING_ZERO_BLANK_EN: digits 2–3 show 7Fh and digit 0 shows 40h.
  - Without it: digits 2–3 show 40h.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digit data and inter-digit blanking.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module display_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 500
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_En,
    input  logic                  i_Load,
    input  logic [4*DIGITS-1:0]   i_Data,
    input  logic [DIGITS-1:0]     i_Dp,
    output logic [6:0]            o_Seg,
    output logic                  o_Dp,
    output logic [DIGITS-1:0]     o_An,
    output logic                  o_Frame
);

    // state    | meaning
    // IDLE     | scan stopped, display dark, pending copied to display every cycle
    // BLANKING | first BLANK cycles of a slot, all anodes off
    // SHOW     | remainder of the slot, digit dig lit
    typedef enum logic [1:0] {IDLE, BLANKING, SHOW} state_t;

    localparam int CW = $clog2(PRESCALE);
    localparam int DW = $clog2(DIGITS);
    localparam int BW = 5 * DIGITS;

    localparam logic [CW-1:0] CNT_LAST       = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [DW-1:0] DIG_LAST       = DW'(DIGITS - 1);
    localparam state_t        SLOT_START     = (BLANK == 0) ? SHOW : BLANKING;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   dig, dig_nxt;
    logic [BW-1:0]   pend, pend_nxt;
    logic [BW-1:0]   disp, disp_nxt;
    logic [BW-1:0]   load_word;
    logic [6:0]      seg_nxt;
    logic            dp_nxt;
    logic [DIGITS-1:0] an_nxt;
    logic            frame_nxt;
    logic [3:0]      disp_nib [DIGITS];
    logic [DIGITS-1:0] disp_dp;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign load_word = {i_Data, i_Dp};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dig_nxt   = dig;
        pend_nxt  = i_Load ? load_word : pend;
        disp_nxt  = disp;
        if (state == IDLE) begin
            cnt_nxt  = '0;
            dig_nxt  = '0;
            disp_nxt = pend;
            if (i_En) state_nxt = SLOT_START;
        end else if (!i_En) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            dig_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = SLOT_START;
            if (dig == DIG_LAST) begin
                dig_nxt = '0;
                // A load landing on the boundary edge goes straight to the display
                disp_nxt = i_Load ? load_word : pend;
            end else begin
                dig_nxt = dig + DW'(1);
            end
        end else begin
            cnt_nxt = cnt + CW'(1);
            if (state == BLANKING && cnt == CNT_BLANK_LAST) state_nxt = SHOW;
        end
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            disp_nib[k] = disp_nxt[DIGITS + 4*k +: 4];
        end
        disp_dp = disp_nxt[DIGITS-1:0];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lead_zero;

    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (disp_nib[DIGITS-1] == 4'h0);
        for (int k = DIGITS - 2; k >= 1; k--) begin
            lead_zero[k] = lead_zero[k+1] && (disp_nib[k] == 4'h0);
        end
    end
`endif

    // Outputs are computed from next-state values so they register on the same edge
    always_comb begin
        seg_nxt   = 7'h7F;
        dp_nxt    = 1'b1;
        an_nxt    = '1;
        frame_nxt = (state_nxt != IDLE) && (cnt_nxt == CNT_LAST) && (dig_nxt == DIG_LAST);
        if (state_nxt == SHOW) begin
            an_nxt[dig_nxt] = 1'b0;
            seg_nxt         = hex7(disp_nib[dig_nxt]);
            dp_nxt          = ~disp_dp[dig_nxt];
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_zero[dig_nxt]) seg_nxt = 7'h7F;
`endif
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dig     <= '0;
            pend    <= '0;
            disp    <= '0;
            o_Seg   <= 7'h7F;
            o_Dp    <= 1'b1;
            o_An    <= '1;
            o_Frame <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dig     <= dig_nxt;
            pend    <= pend_nxt;
            disp    <= disp_nxt;
            o_Seg   <= seg_nxt;
            o_Dp    <= dp_nxt;
            o_An    <= an_nxt;
            o_Frame <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (DIGITS=4, PRESCALE=8, BLANK=2); honours LEADING_ZERO_BLANK_EN.
module tb_display_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        i_Clk = 1'b0;
    logic        i_Rst, i_En, i_Load;
    logic [15:0] i_Data;
    logic [3:0]  i_Dp;
    logic [6:0]  o_Seg;
    logic        o_Dp;
    logic [3:0]  o_An;
    logic        o_Frame;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fr;
    } exp_t;

    exp_t q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tab [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] s4321 [4]    = '{7'h79, 7'h24, 7'h30, 7'h19};

    // Reference: position within the frame as a single cycle count since enable
    bit          m_act;
    int          m_t;
    logic [15:0] m_pd, m_dd;
    logic [3:0]  m_pp, m_dp;

    display_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_En(i_En), .i_Load(i_Load),
        .i_Data(i_Data), .i_Dp(i_Dp), .o_Seg(o_Seg), .o_Dp(o_Dp),
        .o_An(o_An), .o_Frame(o_Frame)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [19:0] newp;
        exp_t e;
        int d, c;
        logic [3:0] nib;
        newp = i_Load ? {i_Data, i_Dp} : {m_pd, m_pp};
        if (i_Rst) begin
            m_act = 0; m_t = 0;
            m_pd = '0; m_pp = '0; m_dd = '0; m_dp = '0;
        end else begin
            if (!m_act) begin
                m_dd = m_pd; m_dp = m_pp;
                if (i_En) begin m_act = 1; m_t = 0; end
            end else if (!i_En) begin
                m_act = 0;
            end else begin
                if (m_t == FRAME - 1) begin m_dd = newp[19:4]; m_dp = newp[3:0]; end
                m_t = (m_t + 1) % FRAME;
            end
            m_pd = newp[19:4]; m_pp = newp[3:0];
        end
        e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fr: 1'b0};
        if (m_act) begin
            d = m_t / PRESCALE;
            c = m_t % PRESCALE;
            e.fr = (m_t == FRAME - 1);
            if (c >= BLANK) begin
                nib  = m_dd[4*d +: 4];
                e.an = ~(4'b0001 << d);
                e.dp = ~m_dp[d];
                e.seg = seg_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
                if (d > 0 && (m_dd >> (4*d)) == 16'h0) e.seg = 7'h7F;
`endif
            end
        end
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge i_Clk);
        model_edge();
        @(negedge i_Clk);
        e = q.pop_front();
        chk("sb_seg",   {25'h0, o_Seg},   {25'h0, e.seg});
        chk("sb_dp",    {31'h0, o_Dp},    {31'h0, e.dp});
        chk("sb_an",    {28'h0, o_An},    {28'h0, e.an});
        chk("sb_frame", {31'h0, o_Frame}, {31'h0, e.fr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int nfr;
        bit found;
        logic [6:0] exp_seg;
        i_Rst = 1; i_En = 1; i_Load = 0; i_Data = '0; i_Dp = '0;

        // reset with enable held high, then release
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_an", {28'h0, o_An}, 32'hF);
            chk("rst_seg", {25'h0, o_Seg}, 32'h7F);
        end
        i_Rst = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("startup_an", {28'h0, o_An}, (k < BLANK) ? 32'hF : 32'hE);
        end

        // scan order and frame pulse
        i_En = 0; step();
        i_Load = 1; i_Data = 16'h4321; i_Dp = 4'h0; step();
        i_Load = 0; step();
        i_En = 1;
        nfr = 0;
        for (int i = 0; i < 2*FRAME; i++) begin
            step();
            if (o_Frame) nfr++;
            if (i % PRESCALE == 5) begin
                chk("scan_an",  {28'h0, o_An},  {28'h0, an_tab[(i/PRESCALE)%4]});
                chk("scan_seg", {25'h0, o_Seg}, {25'h0, s4321[(i/PRESCALE)%4]});
            end
            if (i % FRAME == FRAME - 1) chk("frame_pos", {31'h0, o_Frame}, 32'h1);
        end
        chk("frame_count", nfr, 2);

        // tear-free update: load during digit 1
        for (int i = 2*FRAME; i < 4*FRAME; i++) begin
            i_Load = (i == 2*FRAME + PRESCALE + 3);
            i_Data = 16'h8888;
            step();
            if (i % PRESCALE == 5) begin
                exp_seg = (i < 3*FRAME) ? s4321[(i/PRESCALE)%4] : 7'h00;
                chk("tear_seg", {25'h0, o_Seg}, {25'h0, exp_seg});
            end
        end
        i_Load = 0;

        // load coincident with frame boundary
        found = 0;
        for (int k = 0; k < 2*FRAME; k++) begin
            if (o_Frame) begin found = 1; break; end
            step();
        end
        chk("frame_seen", {31'h0, found}, 32'h1);
        i_Load = 1; i_Data = 16'hFFFF; step();
        i_Load = 0;
        for (int k = 0; k < 5; k++) step();
        chk("bypass_seg", {25'h0, o_Seg}, 32'h0E);
        chk("bypass_an", {28'h0, o_An}, 32'hE);

        // disable at cnt 4 of digit 2, re-enable after 5 cycles
        for (int k = 0; k < 15; k++) step();
        chk("dis_pre_an", {28'h0, o_An}, 32'hB);
        i_En = 0;
        step();
        chk("dis_an", {28'h0, o_An}, 32'hF);
        for (int k = 0; k < 4; k++) step();
        i_En = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("restart_an", {28'h0, o_An}, (k < BLANK) ? 32'hF : 32'hE);
        end

        // decimal point and leading zeros
        i_En = 0; step();
        i_Load = 1; i_Data = 16'h0050; i_Dp = 4'b0010; step();
        i_Load = 0; step();
        i_En = 1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i % PRESCALE == 0) chk("dp_blank", {31'h0, o_Dp}, 32'h1);
            if (i % PRESCALE == 5) begin
                chk("dp_show", {31'h0, o_Dp}, (i/PRESCALE == 1) ? 32'h0 : 32'h1);
                case (i/PRESCALE)
                    0: exp_seg = 7'h40;
                    1: exp_seg = 7'h12;
`ifdef LEADING_ZERO_BLANK_EN
                    default: exp_seg = 7'h7F;
`else
                    default: exp_seg = 7'h40;
`endif
                endcase
                chk("lz_seg", {25'h0, o_Seg}, {25'h0, exp_seg});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
